// File: rtl/fifo_burst_reader.sv
// Burst read controller for the 32-bit x 4 synchronous FIFO. It drains the FIFO
// onto a valid/ready stream, starting on full or after a partial-fill timeout.
module fifo_burst_reader #(
    parameter int FWIDTH    = 32,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              En,
    input  logic [FWIDTH-1:0] F_Data,
    input  logic              F_EmptyN,
    input  logic              F_FullN,
    input  logic              F_FirstN,
    output logic              FOutN,
    output logic [FWIDTH-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Out_Last,
    output logic              Abort,
    output logic              Busy
);

    // state | meaning
    // IDLE  | no burst; waits for data with En=1
    // WAIT  | FIFO partially filled; timer runs until full or timeout
    // BURST | popping words onto the output stream
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] TIMER_EXP = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(BURST_LEN - 1);

    state_t            r_state;
    logic [TW-1:0]     r_timer;
    logic [CW-1:0]     r_count;
    logic [FWIDTH-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_abort;

    logic w_pop;
    logic w_last;

    assign w_pop  = (r_state == S_BURST) && F_EmptyN && (!r_out_valid || Out_Ready);
    assign w_last = (r_count == LAST_CNT) || !F_FirstN;

    assign FOutN     = !w_pop;
    assign Out_Data  = r_out_data;
    assign Out_Valid = r_out_valid;
    assign Out_Last  = r_out_last;
    assign Abort     = r_abort;
    assign Busy      = (r_state != S_IDLE) || r_out_valid;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= 1'b0;

            // A pop refills the output register even in the accept cycle.
            if (w_pop) begin
                r_out_data  <= F_Data;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last;
            end else if (r_out_valid && Out_Ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (En && F_EmptyN) begin
                        if (!F_FullN) begin
                            r_state <= S_BURST;
                            r_count <= '0;
                        end else begin
                            r_state <= S_WAIT;
                            r_timer <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_timer != TIMER_MAX)
                        r_timer <= r_timer + TW'(1);
                    if (!En || !F_EmptyN) begin
                        r_state <= S_IDLE;
                    end else if (!F_FullN || (r_timer == TIMER_EXP)) begin
                        r_state <= S_BURST;
                        r_count <= '0;
                    end
                end
                S_BURST: begin
                    if (w_pop) begin
                        r_count <= r_count + CW'(1);
                        if (w_last)
                            r_state <= S_IDLE;
                    end else if (!F_EmptyN) begin
                        // FIFO was cleared under us before the last word.
                        r_abort <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural 4-deep FIFO feeds the DUT and a
// scoreboard of written words is compared against the output handshakes.
module tb_fifo_burst_reader;

    localparam int FW = 32;
    localparam int BL = 4;
    localparam int TO = 16;

    logic          Clk = 1'b0;
    logic          RstN = 1'b0;
    logic          En = 1'b0;
    logic          Out_Ready = 1'b0;
    logic [FW-1:0] F_Data;
    logic          F_EmptyN, F_FullN, F_FirstN;
    logic          FOutN;
    logic [FW-1:0] Out_Data;
    logic          Out_Valid, Out_Last, Abort, Busy;

    always #5 Clk = ~Clk;

    fifo_burst_reader #(.FWIDTH(FW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .Clk       (Clk),
        .RstN      (RstN),
        .En        (En),
        .F_Data    (F_Data),
        .F_EmptyN  (F_EmptyN),
        .F_FullN   (F_FullN),
        .F_FirstN  (F_FirstN),
        .FOutN     (FOutN),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Last  (Out_Last),
        .Abort     (Abort),
        .Busy      (Busy)
    );

    // FIFO model: registered flags derived from the fill count, combinational head.
    logic [FW-1:0] mem [BL];
    logic [1:0]    wp = 2'd0;
    logic [1:0]    rp = 2'd0;
    logic [2:0]    cnt = 3'd0;
    logic          wr = 1'b0;
    logic          clr = 1'b0;
    logic [FW-1:0] wdata = '0;
    logic          pop_f, push_f;

    assign pop_f    = !FOutN && (cnt != 3'd0);
    assign push_f   = wr && ((cnt != 3'd4) || pop_f);
    assign F_Data   = mem[rp];
    assign F_EmptyN = (cnt != 3'd0);
    assign F_FullN  = (cnt != 3'd4);
    assign F_FirstN = (cnt != 3'd1);

    always @(posedge Clk) begin
        if (clr) begin
            cnt <= 3'd0;
            wp  <= 2'd0;
            rp  <= 2'd0;
        end else begin
            if (push_f) begin
                mem[wp] <= wdata;
                wp      <= wp + 2'd1;
            end
            if (pop_f)
                rp <= rp + 2'd1;
            cnt <= cnt + {2'b00, push_f} - {2'b00, pop_f};
        end
    end

    typedef struct packed {
        logic [FW-1:0] d;
        logic          l;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pop = 0;
    int   n_abort = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (RstN) begin
            if (!FOutN) begin
                n_pop++;
                chk("pop_nonempty", 64'(F_EmptyN), 64'd1);
            end
            if (Abort)
                n_abort++;
            if (Out_Valid && Out_Ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 64'(Out_Data), 64'h1_0000_0000);
                end else begin
                    e = q.pop_front();
                    chk("out_data", 64'(Out_Data), 64'(e.d));
                    chk("out_last", 64'(Out_Last), 64'(e.l));
                end
            end
        end
    end

    task automatic wr_word(input logic [FW-1:0] d, input logic deliver, input logic last);
        exp_t t;
        t.d = d;
        t.l = last;
        if (deliver)
            q.push_back(t);
        wr    = 1'b1;
        wdata = d;
        @(posedge Clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic count_to_pop(input int limit, output int n);
        n = 0;
        @(negedge Clk);
        while (FOutN && (n < limit)) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((Busy || (q.size() != 0)) && (n < 300)) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_busy"}, 64'(Busy), 64'd0);
        chk({tag, "_sb_left"}, 64'(q.size()), 64'd0);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        int a0;
        int busy_n;

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_valid", 64'(Out_Valid), 64'd0);
        chk("rst_last", 64'(Out_Last), 64'd0);
        chk("rst_abort", 64'(Abort), 64'd0);
        chk("rst_foutn", 64'(FOutN), 64'd1);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_data", 64'(Out_Data), 64'd0);
        RstN = 1'b1;
        @(posedge Clk);
        #1;

        // Full-FIFO burst at one word per cycle
        En = 1'b1;
        Out_Ready = 1'b1;
        wr_word(32'hA0, 1'b1, 1'b0);
        wr_word(32'hA1, 1'b1, 1'b0);
        wr_word(32'hA2, 1'b1, 1'b0);
        wr_word(32'hA3, 1'b1, 1'b1);
        count_to_pop(20, n);
        chk("t1_gap", 64'(n), 64'd1);
        for (int i = 1; i < BL; i++) begin
            @(negedge Clk);
            chk("t1_pop_run", 64'(FOutN), 64'd0);
        end
        @(negedge Clk);
        chk("t1_pop_end", 64'(FOutN), 64'd1);
        wait_done("t1");

        // Single word drains only after the timeout
        a0 = n_abort;
        p0 = n_pop;
        wr_word(32'hDEADBEEF, 1'b1, 1'b1);
        count_to_pop(40, n);
        chk("t2_wait_cycles", 64'(n), 64'(TO + 1));
        wait_done("t2");
        chk("t2_pops", 64'(n_pop - p0), 64'd1);
        chk("t2_abort", 64'(n_abort - a0), 64'd0);

        // Downstream stall after the first word
        Out_Ready = 1'b0;
        p0 = n_pop;
        wr_word(32'hB0, 1'b1, 1'b0);
        wr_word(32'hB1, 1'b1, 1'b0);
        wr_word(32'hB2, 1'b1, 1'b0);
        wr_word(32'hB3, 1'b1, 1'b1);
        repeat (10) @(negedge Clk);
        chk("t3_stall_pops", 64'(n_pop - p0), 64'd1);
        chk("t3_stall_valid", 64'(Out_Valid), 64'd1);
        chk("t3_stall_data", 64'(Out_Data), 64'hB0);
        chk("t3_stall_foutn", 64'(FOutN), 64'd1);
        @(posedge Clk);
        #1;
        Out_Ready = 1'b1;
        wait_done("t3");
        chk("t3_pops", 64'(n_pop - p0), 64'd4);

        // FIFO cleared after two pops of a four-word burst
        p0 = n_pop;
        a0 = n_abort;
        wr_word(32'hC0, 1'b1, 1'b0);
        wr_word(32'hC1, 1'b1, 1'b0);
        wr_word(32'hC2, 1'b0, 1'b0);
        wr_word(32'hC3, 1'b0, 1'b0);
        count_to_pop(20, n);
        @(posedge Clk);
        #1;
        clr = 1'b1;
        @(posedge Clk);
        #1;
        clr = 1'b0;
        wait_done("t4");
        repeat (5) @(negedge Clk);
        chk("t4_pops", 64'(n_pop - p0), 64'd2);
        chk("t4_abort_cycles", 64'(n_abort - a0), 64'd1);
        @(posedge Clk);
        #1;

        // En low holds off a full FIFO
        En = 1'b0;
        p0 = n_pop;
        wr_word(32'hD0, 1'b1, 1'b0);
        wr_word(32'hD1, 1'b1, 1'b0);
        wr_word(32'hD2, 1'b1, 1'b0);
        wr_word(32'hD3, 1'b1, 1'b1);
        busy_n = 0;
        repeat (50) begin
            @(negedge Clk);
            if (Busy)
                busy_n++;
        end
        chk("t5_no_pops", 64'(n_pop - p0), 64'd0);
        chk("t5_busy_cycles", 64'(busy_n), 64'd0);
        @(posedge Clk);
        #1;
        En = 1'b1;
        count_to_pop(10, n);
        chk("t5_en_latency", 64'(n), 64'd1);
        wait_done("t5");

        // Reset mid-burst drops the held word
        Out_Ready = 1'b0;
        wr_word(32'hE0, 1'b0, 1'b0);
        wr_word(32'hE1, 1'b1, 1'b0);
        wr_word(32'hE2, 1'b1, 1'b0);
        wr_word(32'hE3, 1'b1, 1'b0);
        n = 0;
        while (!Out_Valid && (n < 20)) begin
            @(negedge Clk);
            n++;
        end
        chk("t6_valid_before_rst", 64'(Out_Valid), 64'd1);
        @(negedge Clk);
        #2;
        RstN = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(Out_Valid), 64'd0);
        chk("t6_rst_foutn", 64'(FOutN), 64'd1);
        chk("t6_rst_data", 64'(Out_Data), 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b1;
        @(posedge Clk);
        #1;
        Out_Ready = 1'b1;
        p0 = n_pop;
        wr_word(32'hE4, 1'b1, 1'b1);
        wait_done("t6");
        chk("t6_pops", 64'(n_pop - p0), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
